// File: rtl/bellek_yonlendirici.sv
// Load/store router from the core memory stage to KANAL_SAYISI slave channels,
// with region decode, read-only protection, single-outstanding handshake and timeout.
//
// state | meaning
// BOSTA | idle, istek_hazir_o high, waiting for a core request
// ISTEK | request held on the selected channel until it accepts
// YANIT | waiting for the selected channel's response pulse
// BITTI | one-cycle response to the core (data or error)
module bellek_yonlendirici #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT = 32,
    parameter int KANAL_SAYISI = 3,
    parameter logic [3*KANAL_SAYISI-1:0] BOLGE_HARITASI = {3'd3, 3'd2, 3'd4},
    parameter logic [KANAL_SAYISI-1:0] SALT_OKU = 3'b100,
    parameter int ZAMAN_ASIMI = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           istek_gecerli_i,
    output logic                           istek_hazir_o,
    input  logic                           bellege_yaz_i,
    input  logic                           bellekten_oku_i,
    input  logic [ADRES_BIT-1:0]           adres_i,
    input  logic [VERI_BIT-1:0]            yaz_veri_i,
    output logic                           yanit_gecerli_o,
    output logic                           hata_o,
    output logic [VERI_BIT-1:0]            oku_veri_o,
    output logic [KANAL_SAYISI-1:0]        kanal_istek_o,
    output logic                           kanal_yaz_o,
    output logic                           kanal_oku_o,
    output logic [ADRES_BIT-1:0]           kanal_adres_o,
    output logic [VERI_BIT-1:0]            kanal_veri_o,
    input  logic [KANAL_SAYISI-1:0]        kanal_hazir_i,
    input  logic [KANAL_SAYISI-1:0]        kanal_yanit_gecerli_i,
    input  logic [KANAL_SAYISI*VERI_BIT-1:0] kanal_oku_veri_i
);

    localparam int SAYAC_BIT = (ZAMAN_ASIMI > 0) ? $clog2(ZAMAN_ASIMI + 1) : 1;
    localparam logic [SAYAC_BIT-1:0] SAYAC_SON =
        (ZAMAN_ASIMI > 0) ? SAYAC_BIT'(ZAMAN_ASIMI - 1) : '0;

    typedef enum logic [1:0] {BOSTA, ISTEK, YANIT, BITTI} durum_t;

    durum_t                  durum, durum_n;
    logic [KANAL_SAYISI-1:0] sec_q, sec_n, bolge_eslesme, cozulen;
    logic [SAYAC_BIT-1:0]    sayac;
    logic [2:0]              bolge;
    logic                    kabul, zaman_doldu, hata_n;
    logic [VERI_BIT-1:0]     veri_n, secili_veri;

    assign bolge         = adres_i[ADRES_BIT-2 -: 3];
    assign istek_hazir_o = (durum == BOSTA);
    assign zaman_doldu   = (ZAMAN_ASIMI != 0) && (sayac == SAYAC_SON);

    always_comb begin
        bolge_eslesme = '0;
        for (int k = 0; k < KANAL_SAYISI; k++)
            bolge_eslesme[k] = (BOLGE_HARITASI[3*k +: 3] == bolge);
    end

    // isolate the lowest matching channel so overlapping map entries resolve to the lowest k
    assign cozulen = bolge_eslesme & (~bolge_eslesme + KANAL_SAYISI'(1));

    always_comb begin
        secili_veri = '0;
        for (int k = 0; k < KANAL_SAYISI; k++)
            if (sec_q[k])
                secili_veri = secili_veri | kanal_oku_veri_i[VERI_BIT*k +: VERI_BIT];
    end

    always_comb begin
        durum_n = durum;
        sec_n   = sec_q;
        hata_n  = hata_o;
        veri_n  = oku_veri_o;
        kabul   = 1'b0;
        case (durum)
            BOSTA: begin
                if (istek_gecerli_i) begin
                    kabul = 1'b1;
                    sec_n = cozulen;
                    if ((cozulen == '0) || (bellege_yaz_i == bellekten_oku_i) ||
                        (bellege_yaz_i && ((cozulen & SALT_OKU) != '0))) begin
                        durum_n = BITTI;
                        hata_n  = 1'b1;
                        veri_n  = '0;
                    end else begin
                        durum_n = ISTEK;
                    end
                end
            end
            ISTEK: begin
                if (zaman_doldu) begin
                    durum_n = BITTI;
                    hata_n  = 1'b1;
                    veri_n  = '0;
                end else if ((kanal_hazir_i & sec_q) != '0) begin
                    durum_n = YANIT;
                end
            end
            YANIT: begin
                // a response in the timeout cycle still completes the access
                if ((kanal_yanit_gecerli_i & sec_q) != '0) begin
                    durum_n = BITTI;
                    hata_n  = 1'b0;
                    veri_n  = kanal_oku_o ? secili_veri : '0;
                end else if (zaman_doldu) begin
                    durum_n = BITTI;
                    hata_n  = 1'b1;
                    veri_n  = '0;
                end
            end
            BITTI: durum_n = BOSTA;
            default: durum_n = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum           <= BOSTA;
            sec_q           <= '0;
            sayac           <= '0;
            kanal_istek_o   <= '0;
            yanit_gecerli_o <= 1'b0;
            hata_o          <= 1'b0;
            oku_veri_o      <= '0;
            kanal_yaz_o     <= 1'b0;
            kanal_oku_o     <= 1'b0;
            kanal_adres_o   <= '0;
            kanal_veri_o    <= '0;
        end else begin
            durum           <= durum_n;
            sec_q           <= sec_n;
            hata_o          <= hata_n;
            oku_veri_o      <= veri_n;
            yanit_gecerli_o <= (durum_n == BITTI);
            kanal_istek_o   <= (durum_n == ISTEK) ? sec_n : '0;
            if (kabul) begin
                sayac         <= '0;
                kanal_yaz_o   <= bellege_yaz_i;
                kanal_oku_o   <= bellekten_oku_i;
                kanal_adres_o <= adres_i;
                kanal_veri_o  <= yaz_veri_i;
            end else if ((durum == ISTEK) || (durum == YANIT)) begin
                sayac <= sayac + SAYAC_BIT'(1);
            end
        end
    end

endmodule

// File: tb/tb_bellek_yonlendirici.sv
// Randomized bench for bellek_yonlendirici: a transaction-level model predicts each
// response (error, data, cycle) into a scoreboard that a negedge monitor drains.
module tb_bellek_yonlendirici;

    localparam int Z = 8;

    logic        clk_i, rst_i;
    logic        istek_gecerli_i, istek_hazir_o;
    logic        bellege_yaz_i, bellekten_oku_i;
    logic [31:0] adres_i, yaz_veri_i;
    logic        yanit_gecerli_o, hata_o;
    logic [31:0] oku_veri_o;
    logic [2:0]  kanal_istek_o;
    logic        kanal_yaz_o, kanal_oku_o;
    logic [31:0] kanal_adres_o, kanal_veri_o;
    logic [2:0]  kanal_hazir_i, kanal_yanit_gecerli_i;
    logic [95:0] kanal_oku_veri_i;

    bellek_yonlendirici #(.ZAMAN_ASIMI(Z)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(istek_hazir_o),
        .bellege_yaz_i(bellege_yaz_i), .bellekten_oku_i(bellekten_oku_i),
        .adres_i(adres_i), .yaz_veri_i(yaz_veri_i),
        .yanit_gecerli_o(yanit_gecerli_o), .hata_o(hata_o), .oku_veri_o(oku_veri_o),
        .kanal_istek_o(kanal_istek_o), .kanal_yaz_o(kanal_yaz_o), .kanal_oku_o(kanal_oku_o),
        .kanal_adres_o(kanal_adres_o), .kanal_veri_o(kanal_veri_o),
        .kanal_hazir_i(kanal_hazir_i), .kanal_yanit_gecerli_i(kanal_yanit_gecerli_i),
        .kanal_oku_veri_i(kanal_oku_veri_i)
    );

    typedef struct {
        logic        hata;
        logic [31:0] veri;
        int          cyc;
    } beklenen_t;

    beklenen_t sb[$];
    int n_test = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [2:0] harita [3] = '{3'd4, 3'd2, 3'd3};
    bit         salt_oku [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish act=timeout req=finish");
        $fatal(1);
    end

    task automatic chk(input string ad, input logic [63:0] act, input logic [63:0] exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", ad, act, exp, cyc);
        end
    endtask

    initial forever begin
        beklenen_t e;
        @(negedge clk_i);
        if (yanit_gecerli_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_test++;
                n_fail++;
                $display("FAIL unexpected_yanit: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("yanit_hata", 64'(hata_o), 64'(e.hata));
                chk("yanit_veri", 64'(oku_veri_o), 64'(e.veri));
                chk("yanit_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic bekle_hazir();
        int n = 0;
        while (istek_hazir_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (istek_hazir_o !== 1'b1) chk("hazir_bekleme", 64'(istek_hazir_o), 64'd1);
    endtask

    task automatic txn(input logic [31:0] adr, input logic [31:0] wd, input logic y,
                       input logic o, input int hd, input int rd, input logic [31:0] rdat);
        int ch, r, lat, t0;
        bit err;
        logic [2:0] oh, exp_ist;
        logic [63:0] ist_a, ist_e, fld_a, fld_e, hz_a, hz_e;
        bit ist_bad, fld_bad, hz_bad;
        beklenen_t e;

        ch = -1;
        for (int k = 2; k >= 0; k--) if (harita[k] == adr[30:28]) ch = k;
        err = 1'b0;
        if (ch < 0) err = 1'b1;
        else if (y == o) err = 1'b1;
        else if (y && salt_oku[ch]) err = 1'b1;
        oh = err ? 3'b000 : 3'(1 << ch);
        r = 2 + hd + rd;
        if (err) lat = 1;
        else lat = (r <= Z) ? r + 1 : Z + 1;
        e.hata = err || (r > Z);
        e.veri = (!e.hata && o) ? rdat : 32'd0;

        bekle_hazir();
        istek_gecerli_i = 1'b1;
        adres_i = adr;
        yaz_veri_i = wd;
        bellege_yaz_i = y;
        bellekten_oku_i = o;
        kanal_hazir_i = 3'($urandom) & ~oh;
        kanal_yanit_gecerli_i = 3'($urandom);
        t0 = cyc;
        e.cyc = t0 + lat;
        sb.push_back(e);

        ist_bad = 0; fld_bad = 0; hz_bad = 0;
        ist_a = 0; ist_e = 0; fld_a = 0; fld_e = 0; hz_a = 0; hz_e = 0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk_i);
            istek_gecerli_i = 1'b0;
            adres_i = $urandom;
            yaz_veri_i = $urandom;
            bellege_yaz_i = 1'($urandom);
            bellekten_oku_i = 1'($urandom);
            exp_ist = (!err && k <= 1 + hd && k <= Z) ? oh : 3'b000;
            if (!ist_bad) begin
                ist_a = 64'(kanal_istek_o); ist_e = 64'(exp_ist);
                ist_bad = (kanal_istek_o !== exp_ist);
            end
            if (!fld_bad && k <= lat) begin
                fld_a = {kanal_adres_o, kanal_veri_o ^ {30'd0, kanal_yaz_o, kanal_oku_o}};
                fld_e = {adr, wd ^ {30'd0, y, o}};
                fld_bad = (fld_a !== fld_e);
            end
            if (!hz_bad) begin
                hz_a = 64'(istek_hazir_o); hz_e = 64'(k == lat + 1);
                hz_bad = (hz_a !== hz_e);
            end
            kanal_hazir_i = (3'($urandom) & ~oh) | ((k == 1 + hd) ? oh : 3'b000);
            kanal_yanit_gecerli_i = (3'($urandom) & ~oh) |
                                    ((k == r) ? oh : 3'b000) |
                                    ((k == 1 && $urandom_range(0, 1) == 1) ? oh : 3'b000);
            kanal_oku_veri_i = {$urandom, $urandom, $urandom};
            if (ch >= 0) kanal_oku_veri_i[32*ch +: 32] = rdat;
        end
        chk("kanal_istek", ist_a, ist_e);
        chk("kanal_alanlar", fld_a, fld_e);
        chk("istek_hazir", hz_a, hz_e);
    endtask

    initial begin
        logic [31:0] a;
        int tip;
        rst_i = 1'b0;
        istek_gecerli_i = 0; bellege_yaz_i = 0; bellekten_oku_i = 0;
        adres_i = 0; yaz_veri_i = 0;
        kanal_hazir_i = 0; kanal_yanit_gecerli_i = 0; kanal_oku_veri_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_hazir", 64'(istek_hazir_o), 64'd1);
        chk("reset_cikislar", 64'(|{kanal_istek_o, yanit_gecerli_o, hata_o, oku_veri_o,
            kanal_yaz_o, kanal_oku_o, kanal_adres_o, kanal_veri_o}), 64'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        txn(32'h4000_0010, 32'h0, 1'b0, 1'b1, 0, 0, 32'hDEAD_BEEF);
        txn(32'h2000_0000, 32'h1234, 1'b1, 1'b0, 4, 0, 32'hAAAA_5555);
        txn(32'h3000_0000, 32'h55, 1'b1, 1'b0, 0, 0, 32'h0);
        txn(32'h3000_0000, 32'h0, 1'b0, 1'b1, 1, 2, 32'hC0FF_EE00);
        txn(32'h1000_0000, 32'h0, 1'b0, 1'b1, 0, 0, 32'h1);
        txn(32'h4000_0000, 32'h0, 1'b1, 1'b1, 0, 0, 32'h2);
        txn(32'hC000_0004, 32'h0, 1'b0, 1'b0, 0, 0, 32'h3);
        txn(32'h4000_0000, 32'h0, 1'b0, 1'b1, 0, 100, 32'h4);
        txn(32'h2000_0040, 32'h0, 1'b0, 1'b1, 3, 3, 32'h0BAD_F00D);
        txn(32'hA000_0040, 32'h0, 1'b0, 1'b1, 3, 4, 32'h5);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            tip = $urandom_range(0, 9);
            txn(a, $urandom,
                (tip == 1) ? 1'b1 : (tip == 0) ? 1'b0 : 1'(tip & 1),
                (tip == 1) ? 1'b1 : (tip == 0) ? 1'b0 : 1'(~tip & 1),
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 2),
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 2),
                $urandom);
        end

        // reset while waiting in YANIT abandons the access
        bekle_hazir();
        istek_gecerli_i = 1'b1; adres_i = 32'h4000_0020; yaz_veri_i = 32'h77;
        bellege_yaz_i = 1'b0; bellekten_oku_i = 1'b1;
        kanal_hazir_i = 3'b000; kanal_yanit_gecerli_i = 3'b000;
        @(negedge clk_i);
        istek_gecerli_i = 1'b0; kanal_hazir_i = 3'b001;
        @(negedge clk_i);
        kanal_hazir_i = 3'b000;
        #2 rst_i = 1'b0;
        #1;
        chk("rst_async_cikislar", 64'(|{kanal_istek_o, yanit_gecerli_o, hata_o, oku_veri_o,
            kanal_yaz_o, kanal_oku_o, kanal_adres_o, kanal_veri_o}), 64'd0);
        chk("rst_async_hazir", 64'(istek_hazir_o), 64'd1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        kanal_yanit_gecerli_i = 3'b001;
        kanal_oku_veri_i[31:0] = 32'h1111_2222;
        @(negedge clk_i);
        kanal_yanit_gecerli_i = 3'b000;
        for (int k = 0; k < 4; k++) begin
            chk("gec_yanit_yok", 64'({yanit_gecerli_o, istek_hazir_o}), 64'b01);
            @(negedge clk_i);
        end

        txn(32'h4000_0010, 32'h0, 1'b0, 1'b1, 0, 0, 32'h1357_9BDF);
        repeat (5) @(negedge clk_i);
        chk("sb_bos", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule

// File: doc/bellek_yonlendirici.md
# bellek_yonlendirici

Parametrised load/store router between the core memory stage and `KANAL_SAYISI` slave channels: data memory, I/O, timer and any later regions. It decodes address bits [30:28] against a per-channel region map and enforces per-channel read-only protection. It runs a single-outstanding request/response handshake with a timeout. Unmapped, illegal or timed-out accesses return an error response instead of being dropped.

## Interface
- `ADRES_BIT`, 32: address width; region field is bits [ADRES_BIT-2 -: 3].
- `VERI_BIT`, 32: data width.
- `KANAL_SAYISI`, 3: number of slave channels (1..8).
- `BOLGE_HARITASI`, {3'd3,3'd2,3'd4}: packed 3-bit region code per channel; channel k uses bits [3k+:3]. Default: ch0=4 data memory, ch1=2 I/O, ch2=3 timer.
- `SALT_OKU`, 3'b100: per-channel read-only mask. Default: timer is read-only.
- `ZAMAN_ASIMI`, 255: cycles allowed from issue to channel response; 0 disables the timeout.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `istek_gecerli_i`  in  1  core request valid.
- `istek_hazir_o`  out  1  router can accept a request.
- `bellege_yaz_i`, `bellekten_oku_i`  in  1 each  request type.
- `adres_i`  in  ADRES_BIT  request address.
- `yaz_veri_i`  in  VERI_BIT  write data.
- `yanit_gecerli_o`  out  1  one-cycle response pulse.
- `hata_o`  out  1  response is an error; valid only with `yanit_gecerli_o`.
- `oku_veri_o`  out  VERI_BIT  read data; 0 for writes and errors.
- `kanal_istek_o`  out  KANAL_SAYISI  one-hot request to channels.
- `kanal_yaz_o`, `kanal_oku_o`  out  1 each  latched request type, shared by all channels.
- `kanal_adres_o`  out  ADRES_BIT  latched address, shared.
- `kanal_veri_o`  out  VERI_BIT  latched write data, shared.
- `kanal_hazir_i`  in  KANAL_SAYISI  per-channel accept.
- `kanal_yanit_gecerli_i`  in  KANAL_SAYISI  per-channel response pulse.
- `kanal_oku_veri_i`  in  KANAL_SAYISI*VERI_BIT  per-channel read data; channel k uses bits [VERI_BIT*k+:VERI_BIT].

## Operation
- Four states: BOSTA, ISTEK, YANIT, BITTI. `istek_hazir_o` = (state==BOSTA), combinational.
- BOSTA: a request is accepted when `istek_gecerli_i` is high. On acceptance the router latches the address, data, type and the selected channel.
  - Selected channel: the lowest k whose map code equals the region field.
  - Go to BITTI with the error flag set if any of these holds:
    - no channel matches;
    - `bellege_yaz_i` equals `bellekten_oku_i` (both low or both high);
    - a write targets a channel with `SALT_OKU[k]=1`.
  - Otherwise go to ISTEK and clear the timeout counter.
- ISTEK: `kanal_istek_o[k]` is held high with stable latched fields. On `kanal_hazir_i[k]`, go to YANIT; `kanal_istek_o` is low from the next cycle.
- YANIT: wait for `kanal_yanit_gecerli_i[k]`.
  - For reads, capture `kanal_oku_veri_i` slice k.
  - For writes, capture 0.
  - Clear the error flag and go to BITTI.
- Timeout: a counter of width $clog2(ZAMAN_ASIMI+1) increments every cycle spent in ISTEK or YANIT.
  - If completion has not occurred in the cycle the counter equals ZAMAN_ASIMI-1, go to BITTI with the error flag set and `kanal_istek_o` dropped.
  - Completion in that same cycle wins over the timeout.
- BITTI: `yanit_gecerli_o`=1 for exactly one cycle, with `hata_o` and `oku_veri_o` from registers. Then return to BOSTA.
- Ignored inputs, with no effect on state:
  - `kanal_hazir_i` or `kanal_yanit_gecerli_i` from non-selected channels;
  - any `kanal_yanit_gecerli_i` outside YANIT;
  - a response arriving in the same cycle as accept.
- Reset (asynchronous, any time):
  - state goes to BOSTA and the counter to 0;
  - `kanal_istek_o`, `yanit_gecerli_o`, `hata_o`, `oku_veri_o`, `kanal_yaz_o`, `kanal_oku_o`, `kanal_adres_o` and `kanal_veri_o` are all 0;
  - `istek_hazir_o` reads 1 during reset (the core must not issue then);
  - an in-flight transaction is abandoned with no response.

## Timing
- Accept at cycle 0 → `kanal_istek_o` high at cycle 1.
- Best case: `kanal_hazir_i` at cycle 1, response at cycle 2, `yanit_gecerli_o` at cycle 3. Each wait cycle adds one cycle.
- Decode error: accept at cycle 0 → `yanit_gecerli_o`/`hata_o` at cycle 1.
- Timeout error: `yanit_gecerli_o`/`hata_o` at cycle ZAMAN_ASIMI+1 after accept.
- Back-to-back: the next request can be accepted in the cycle after BITTI.
- All outputs are registered except `istek_hazir_o`.

## Test plan
- Read from 0x4000_0010, ch0 `kanal_hazir_i` and response at the earliest cycles with data 0xDEADBEEF → `kanal_istek_o`=3'b001 at cycle 1; `yanit_gecerli_o`=1, `oku_veri_o`=0xDEADBEEF, `hata_o`=0 at cycle 3.
- Write 0x1234 to 0x2000_0000, ch1 `kanal_hazir_i` delayed 4 cycles → `kanal_veri_o`=0x1234 stable throughout; response pulse with `oku_veri_o`=0 and `hata_o`=0.
- Write to timer 0x3000_0000 → no `kanal_istek_o`; `hata_o`=1 at cycle 1. Read from the same address succeeds via ch2.
- Read from unmapped 0x1000_0000, and a request with both type bits high → error pulse at cycle 1 for each; channels never requested.
- ZAMAN_ASIMI=8, ch0 accepts but never responds → `hata_o`=1 at cycle 9; a stray ch1 response during the wait is ignored; the next request is accepted at cycle 10.
- Assert `rst_i`=0 while in YANIT → all outputs 0 immediately; a late ch0 response after release produces no `yanit_gecerli_o`.
